// File: rtl/pc_sequencer.sv
// Program-counter sequencer: halt/return/jump/branch/sequential next-PC selection.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH     = 16,
    parameter int unsigned         INSTR_BYTES  = 2,
    parameter int unsigned         BR_IMM_W     = 6,
    parameter int unsigned         JMP_IMM_W    = 12,
    parameter int unsigned         RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk_pi,
    input  logic                 reset_n_pi,
    input  logic                 clk_en_pi,
    input  logic                 halt_pi,
    input  logic                 branch_taken_pi,
    input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
    input  logic                 jump_taken_pi,
    input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
    input  logic                 call_pi,
    input  logic                 return_pi,
    output logic [PC_WIDTH-1:0]  pc_po,
    output logic                 ras_full_po,
    output logic                 ras_empty_po,
    output logic                 ras_err_po
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] br_off;
    logic [PC_WIDTH-1:0] jmp_off;

    // Offsets are two's complement; the signed cast sign-extends to PC width.
    assign seq     = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign br_off  = PC_WIDTH'($signed(branch_immediate_pi));
    assign jmp_off = PC_WIDTH'($signed(jump_immediate_pi));

`ifdef PC_SEQUENCER_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                full_q;
    logic                empty_q;
    logic                err_q;
    logic                err_d;
    logic                push;
    logic                pop;
    logic                stk_empty;
    logic                stk_full;
    logic [PC_WIDTH-1:0] ras_top;

    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_mem[wr_ptr_q - PTR_W'(1)];

    // Next-PC selection with return stack control.
    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        err_d = err_q;
        if (halt_pi) begin
            pc_d = pc_q;
        end else if (return_pi) begin
            if (stk_empty) begin
                pc_d  = seq;
                err_d = 1'b1;
            end else begin
                pc_d = ras_top;
                pop  = 1'b1;
            end
        end else if (jump_taken_pi) begin
            pc_d = seq + jmp_off;
            push = call_pi;
            if (call_pi && stk_full) begin
                err_d = 1'b1;
            end
        end else if (branch_taken_pi) begin
            pc_d = seq + br_off;
        end else begin
            pc_d = seq;
        end
    end

    // Circular buffer: a push onto a full stack lands on the oldest slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!stk_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            wr_ptr_d = wr_ptr_q - PTR_W'(1);
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
        end else if (clk_en_pi) begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CNT_W'(RAS_DEPTH));
            empty_q  <= (cnt_d == '0);
            err_q    <= err_d;
        end
    end

    // Stack contents need no reset; the count defines which entries are valid.
    always_ff @(posedge clk_pi) begin
        if (clk_en_pi && push) begin
            ras_mem[wr_ptr_q] <= seq;
        end
    end

    assign ras_full_po  = full_q;
    assign ras_empty_po = empty_q;
    assign ras_err_po   = err_q;
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{call_pi, return_pi};

    // Next-PC selection without a return stack.
    always_comb begin
        pc_d = pc_q;
        if (halt_pi) begin
            pc_d = pc_q;
        end else if (jump_taken_pi) begin
            pc_d = seq + jmp_off;
        end else if (branch_taken_pi) begin
            pc_d = seq + br_off;
        end else begin
            pc_d = seq;
        end
    end

    assign ras_full_po  = 1'b0;
    assign ras_empty_po = 1'b1;
    assign ras_err_po   = 1'b0;
`endif

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            pc_q <= RESET_VECTOR;
        end else if (clk_en_pi) begin
            pc_q <= pc_d;
        end
    end

    assign pc_po = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow the
// PC_SEQUENCER_RAS_EN setting the design is built with.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk_pi = 1'b0;
    logic        reset_n_pi;
    logic        clk_en_pi;
    logic        halt_pi;
    logic        branch_taken_pi;
    logic [5:0]  branch_immediate_pi;
    logic        jump_taken_pi;
    logic [11:0] jump_immediate_pi;
    logic        call_pi;
    logic        return_pi;
    logic [15:0] pc_po;
    logic        ras_full_po;
    logic        ras_empty_po;
    logic        ras_err_po;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_pc;
    logic [15:0] ret_exp [4] = '{16'h042C, 16'h032A, 16'h0228, 16'h0126};

    pc_sequencer dut (
        .clk_pi              (clk_pi),
        .reset_n_pi          (reset_n_pi),
        .clk_en_pi           (clk_en_pi),
        .halt_pi             (halt_pi),
        .branch_taken_pi     (branch_taken_pi),
        .branch_immediate_pi (branch_immediate_pi),
        .jump_taken_pi       (jump_taken_pi),
        .jump_immediate_pi   (jump_immediate_pi),
        .call_pi             (call_pi),
        .return_pi           (return_pi),
        .pc_po               (pc_po),
        .ras_full_po         (ras_full_po),
        .ras_empty_po        (ras_empty_po),
        .ras_err_po          (ras_err_po)
    );

    always #5 clk_pi = ~clk_pi;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one request set for a single enabled edge, then return to idle.
    task automatic cyc(input logic h, input logic br, input logic [5:0] bi,
                       input logic j, input logic [11:0] ji, input logic c, input logic r);
        halt_pi             = h;
        branch_taken_pi     = br;
        branch_immediate_pi = bi;
        jump_taken_pi       = j;
        jump_immediate_pi   = ji;
        call_pi             = c;
        return_pi           = r;
        @(posedge clk_pi);
        #1;
        halt_pi = 0; branch_taken_pi = 0; jump_taken_pi = 0; call_pi = 0; return_pi = 0;
        branch_immediate_pi = '0; jump_immediate_pi = '0;
    endtask

    initial begin
        reset_n_pi = 0; clk_en_pi = 1;
        halt_pi = 0; branch_taken_pi = 0; branch_immediate_pi = '0;
        jump_taken_pi = 0; jump_immediate_pi = '0; call_pi = 0; return_pi = 0;
        #12;
        check_eq("rst_pc", pc_po, 32'h0);
        check_eq("rst_empty", ras_empty_po, 1);
        check_eq("rst_full", ras_full_po, 0);
        check_eq("rst_err", ras_err_po, 0);
        @(negedge clk_pi);
        reset_n_pi = 1;

        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            check_eq("seq_pc", pc_po, 32'(2 * i));
        end

        clk_en_pi = 0;
        cyc(0, 1, 6'b111100, 0, 0, 0, 0);
        check_eq("en_low_hold", pc_po, 32'h6);
        clk_en_pi = 1;

        cyc(0, 0, 0, 1, 12'h008, 0, 0);
        check_eq("jump_fwd", pc_po, 32'h10);
        cyc(0, 1, 6'b111100, 0, 0, 0, 0);
        check_eq("branch_neg", pc_po, 32'h0E);
        cyc(0, 0, 0, 1, 12'hFEE, 0, 0);
        check_eq("jump_neg", pc_po, 32'hFFFE);
        cyc(0, 0, 0, 1, 12'h000, 0, 0);
        check_eq("jump_wrap", pc_po, 32'h0);
        cyc(0, 1, 6'b000100, 1, 12'h01E, 0, 0);
        check_eq("jump_over_branch", pc_po, 32'h20);

        cyc(0, 0, 0, 1, 12'h040, 1, 0);
        check_eq("call_pc", pc_po, 32'h62);
        check_eq("call_empty", ras_empty_po, RAS ? 0 : 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check_eq("ret_pc", pc_po, RAS ? 32'h22 : 32'h64);
        check_eq("ret_empty", ras_empty_po, 1);

        exp_pc = RAS ? 16'h0022 : 16'h0064;
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 1, 12'h100, 1, 0);
            exp_pc = exp_pc + 16'h0102;
            check_eq("nest_call_pc", pc_po, 32'(exp_pc));
            if (i == 4) begin
                check_eq("four_full", ras_full_po, RAS ? 1 : 0);
                check_eq("four_err", ras_err_po, 0);
            end
        end
        check_eq("five_full", ras_full_po, RAS ? 1 : 0);
        check_eq("five_err", ras_err_po, RAS ? 1 : 0);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            exp_pc = RAS ? ret_exp[i] : exp_pc + 16'h2;
            check_eq("nest_ret_pc", pc_po, 32'(exp_pc));
        end
        check_eq("nest_ret_empty", ras_empty_po, 1);
        check_eq("nest_ret_full", ras_full_po, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        exp_pc = exp_pc + 16'h2;
        check_eq("underflow_pc", pc_po, 32'(exp_pc));
        check_eq("underflow_err", ras_err_po, RAS ? 1 : 0);

        cyc(1, 1, 6'b000100, 0, 0, 0, 0);
        check_eq("halt_branch", pc_po, 32'(exp_pc));
        cyc(1, 0, 0, 1, 12'h040, 1, 0);
        check_eq("halt_call_pc", pc_po, 32'(exp_pc));
        check_eq("halt_call_empty", ras_empty_po, 1);
        check_eq("err_sticky", ras_err_po, RAS ? 1 : 0);

        #3 reset_n_pi = 0;
        #1;
        check_eq("async_rst_pc", pc_po, 32'h0);
        check_eq("async_rst_err", ras_err_po, 0);
        check_eq("async_rst_empty", ras_empty_po, 1);
        #2 reset_n_pi = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("post_rst_pc", pc_po, 32'h2);

        cyc(0, 0, 0, 1, 12'h040, 1, 1);
        check_eq("ret_call_pc", pc_po, RAS ? 32'h4 : 32'h44);
        check_eq("ret_call_empty", ras_empty_po, 1);
        check_eq("ret_call_err", ras_err_po, RAS ? 1 : 0);
        exp_pc = RAS ? 16'h0006 : 16'h0046;
        cyc(0, 0, 0, 0, 0, 1, 0);
        check_eq("call_no_jump_pc", pc_po, 32'(exp_pc));
        check_eq("call_no_jump_empty", ras_empty_po, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PC_WIDTH, 16, program counter width in bits.
- INSTR_BYTES, 2, sequential increment per instruction.
- BR_IMM_W, 6, branch immediate width, two's complement.
- JMP_IMM_W, 12, jump immediate width, two's complement.
- RAS_DEPTH, 4, return-address stack entries (power of 2, at least 2).
- RESET_VECTOR, 0, PC value after reset.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_pi, in, 1, single clock; all state updates on the rising edge.
- reset_n_pi, in, 1, reset, asynchronous, active-low.
- clk_en_pi, in, 1, advance enable; when low, no state changes.
- halt_pi, in, 1, hold the PC.
- branch_taken_pi, in, 1, taken conditional branch.
- branch_immediate_pi, in, BR_IMM_W, branch offset.
- jump_taken_pi, in, 1, unconditional jump.
- jump_immediate_pi, in, JMP_IMM_W, jump offset.
- call_pi, in, 1, qualifies a jump as a call (push return address).
- return_pi, in, 1, pop the return stack into the PC.
- pc_po, out, PC_WIDTH, current PC, registered.
- ras_full_po, out, 1, stack holds RAS_DEPTH entries.
- ras_empty_po, out, 1, stack holds 0 entries.
- ras_err_po, out, 1, sticky overflow/underflow flag.

Function
REQ-003 Inputs SHALL be sampled only at rising edges where clk_en_pi=1; otherwise all state SHALL hold.
REQ-004 Define seq = PC + INSTR_BYTES. All arithmetic SHALL be modulo 2^PC_WIDTH, with wrap-around and no error flag.
REQ-005 The next-PC priority SHALL be: halt > return > jump > branch > sequential.
REQ-006 halt_pi=1 SHALL hold the PC and the stack; all other requests in that cycle SHALL be discarded.
REQ-007 Branch: next PC SHALL be seq + sign-extended branch_immediate_pi.
REQ-008 Jump: next PC SHALL be seq + sign-extended jump_immediate_pi.
REQ-009 jump_taken_pi=1 with call_pi=1 SHALL push seq onto the stack in the same cycle as the jump.
REQ-010 call_pi without jump_taken_pi SHALL be ignored.
REQ-011 Return on a non-empty stack SHALL load the top entry into the PC and pop it.
REQ-012 Return on an empty stack SHALL advance to seq and set ras_err_po.
REQ-013 A call with a full stack SHALL overwrite the oldest entry (circular buffer), keep ras_full_po=1, and set ras_err_po.
REQ-014 When return and call are asserted together, the return SHALL win; no push SHALL occur.
REQ-015 pc_po and the flags SHALL reflect the new state one cycle after the sampling edge; there SHALL be no combinational path from any input to any output.
REQ-016 ras_err_po SHALL remain set until reset.

Reset
REQ-017 reset_n_pi=0 SHALL immediately, independent of clk_pi and clk_en_pi, set: PC=RESET_VECTOR, stack count=0, ras_empty_po=1, ras_full_po=0, ras_err_po=0.
REQ-018 Reset asserted mid-operation SHALL discard all pending requests and stack contents.
REQ-019 The first rising edge after deassertion with clk_en_pi=1 SHALL perform a normal update.

Configuration
REQ-020 With macro PC_SEQUENCER_RAS_EN defined, the return stack and REQ-009 to REQ-014 SHALL be implemented.
REQ-021 Without PC_SEQUENCER_RAS_EN:
- No stack storage SHALL be built.
- call_pi and return_pi SHALL be ignored; a call with jump_taken_pi=1 SHALL act as a plain jump.
- Outputs SHALL be tied: ras_full_po=0, ras_empty_po=1, ras_err_po=0.
- The port list SHALL be unchanged.

Verification (defaults, macro defined)
REQ-022 Reset, then 3 enabled cycles with no requests SHALL give pc_po = 0x0000, 0x0002, 0x0004, 0x0006.
REQ-023 At PC=0x0010, branch_taken_pi=1 with immediate 6'b111100 (-4) SHALL give next pc_po = 0x000E; a jump at PC=0xFFFE with immediate 0x000 SHALL give pc_po = 0x0000 (wrap).
REQ-024 At PC=0x0020, jump+call with immediate 0x040 SHALL give PC=0x0062; a later return SHALL give PC=0x0022, ras_empty_po=1.
REQ-025 Five nested calls SHALL set ras_full_po=1 and ras_err_po=1; four returns SHALL restore the four most recent return addresses; a fifth return SHALL give PC=seq.
REQ-026 halt_pi=1 together with branch_taken_pi=1 SHALL hold pc_po; asserting reset_n_pi=0 between clock edges SHALL force pc_po=0x0000 before the next edge.
